// File: rtl/sram_if.sv
// Request/response bundle between the memory-access stage and the data SRAM.
interface sram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              addr_ready;
    logic              read_pulse;
    logic              write_pulse;
    logic [DATA_W-1:0] datain;
    logic [DATA_W-1:0] dataout;
    logic              f_ready;

    // Requester side: drives the request, observes completion.
    modport master (
        output addr, addr_ready, read_pulse, write_pulse, datain,
        input  dataout, f_ready
    );

    // Memory side: samples the request, returns data and completion.
    modport slave (
        input  addr, addr_ready, read_pulse, write_pulse, datain,
        output dataout, f_ready
    );
endinterface

// File: rtl/sram.sv
// Word-organised data memory with a pulse handshake and fixed completion latency.
// One transaction at a time: IDLE accepts, BUSY counts down, DONE commits and
// pulses f_ready, then back to IDLE.
module sram #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst,
    sram_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Latched request
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  dat_q;
    logic               wr_q;
    logic               inr_q;

    logic [DATA_W-1:0]  dout_q;
    logic               f_ready_q;

    logic               accept;
    logic               commit;
    logic               req_in_range;

    // Storage; starts at zero and is deliberately untouched by rst.
    logic [DATA_W-1:0]  mem_q [DEPTH] = '{default: '0};

    // Any set bit above the word-index field puts the byte address past the array.
    assign req_in_range = (bus.addr[ADDR_W-1:IDX_W+2] == '0);

    // Byte-offset bits are intentionally unused (word-aligned access).
    logic unused_ok;
    assign unused_ok = ^bus.addr[1:0];

    // State and latency counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.addr_ready && (bus.read_pulse || bus.write_pulse)) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: accept strobe in IDLE, commit strobe on the edge entering DONE
    always_comb begin
        accept = 1'b0;
        commit = 1'b0;
        case (state_q)
            IDLE:    accept = bus.addr_ready && (bus.read_pulse || bus.write_pulse);
            BUSY:    commit = (cnt_q == '0);
            default: ;
        endcase
    end

    // Request latch; a simultaneous read+write is treated as a write
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            dat_q <= '0;
            wr_q  <= 1'b0;
            inr_q <= 1'b0;
        end else if (accept) begin
            idx_q <= bus.addr[IDX_W+1:2];
            dat_q <= bus.datain;
            wr_q  <= bus.write_pulse;
            inr_q <= req_in_range;
        end
    end

    // Array write on completion; out-of-range writes are dropped, reset aborts
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_q && inr_q) mem_q[idx_q] <= dat_q;
    end

    // Read data and completion pulse; dataout only moves on a completed read
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q    <= '0;
            f_ready_q <= 1'b0;
        end else begin
            f_ready_q <= commit;
            if (commit && !wr_q) dout_q <= inr_q ? mem_q[idx_q] : '0;
        end
    end

    assign bus.dataout = dout_q;
    assign bus.f_ready = f_ready_q;

endmodule

// File: tb/tb_sram.sv
// Directed plus randomized checks of the data SRAM against a word-array model.
module tb_sram;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: plain word array plus the last completed read value
    logic [DATA_W-1:0] mem_m [DEPTH];
    logic [DATA_W-1:0] exp_dout;
    int vectors = 0;
    int fails   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [31:0] a);
        if (a < DEPTH * 4) return mem_m[a[11:2]];
        return '0;
    endfunction

    // One transaction: drive request, scramble inputs while busy, check latency,
    // data and the single-cycle width of f_ready.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input bit disturb, input string tag);
        int lat;
        @(negedge clk);
        bus.addr = a; bus.datain = d; bus.addr_ready = 1'b1;
        bus.read_pulse = rd; bus.write_pulse = wr;
        @(negedge clk);
        bus.read_pulse = 1'b0; bus.write_pulse = 1'b0;
        bus.addr_ready = 1'($urandom_range(0, 1));
        bus.addr = $urandom; bus.datain = $urandom;
        if (wr) begin
            if (a < DEPTH * 4) mem_m[a[11:2]] = d;
        end else begin
            exp_dout = model_read(a);
        end
        lat = 0;
        while (bus.f_ready !== 1'b1 && lat < 20) begin
            if (disturb && lat == 0) begin
                bus.addr_ready = 1'b1; bus.write_pulse = 1'b1;
                bus.addr = a; bus.datain = ~d;
            end
            @(negedge clk);
            bus.write_pulse = 1'b0;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(LATENCY));
        check({tag, "_dout"}, bus.dataout, exp_dout);
        @(negedge clk);
        check({tag, "_frlow"}, 32'(bus.f_ready), 32'd0);
        bus.addr_ready = 1'b0;
    endtask

    initial begin
        int highs;
        logic [31:0] a, d;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        exp_dout = '0;
        bus.addr = '0; bus.addr_ready = 1'b0; bus.read_pulse = 1'b0;
        bus.write_pulse = 1'b0; bus.datain = '0;

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_fready", 32'(bus.f_ready), 32'd0);
        check("rst_dout", bus.dataout, 32'd0);
        txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "rd0");

        // Write then read back
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "wr10");
        txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "rd10");

        // Gating: no addr_ready means no transaction
        @(negedge clk);
        bus.addr = 32'h10; bus.addr_ready = 1'b0; bus.read_pulse = 1'b1;
        @(negedge clk);
        bus.read_pulse = 1'b0;
        highs = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.f_ready === 1'b1) highs++;
        end
        check("gate_nofready", 32'(highs), 32'd0);

        // Write pulse during BUSY is ignored
        txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, "busy_dist");
        txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "busy_chk");

        // Simultaneous read+write is a write; dataout holds
        txn(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, "simul");
        txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "rd20");

        // Alignment and bounds
        txn(1'b0, 1'b1, 32'h13, 32'hA5A5A5A5, 1'b0, "wr13");
        txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "rd10b");
        txn(1'b0, 1'b1, DEPTH * 4, 32'hCAFEF00D, 1'b0, "wr_oob");
        txn(1'b1, 1'b0, DEPTH * 4, 32'h0, 1'b0, "rd_oob");
        txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "rd0_alias");

        // Abort: reset during BUSY drops the write and the completion
        @(negedge clk);
        bus.addr = 32'h40; bus.datain = 32'h55; bus.addr_ready = 1'b1; bus.write_pulse = 1'b1;
        @(negedge clk);
        bus.write_pulse = 1'b0; bus.addr_ready = 1'b0;
        rst = 1'b1;
        highs = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.f_ready === 1'b1) highs++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.f_ready === 1'b1) highs++;
        end
        check("abort_nofready", 32'(highs), 32'd0);
        exp_dout = '0;
        check("abort_dout", bus.dataout, exp_dout);
        txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, "abort_rd40");

        // Randomized traffic, biased toward a small window so reads hit writes
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(DEPTH * 4 - 4, DEPTH * 4 + 64);
                1:       a = $urandom;
                default: a = $urandom_range(0, 255);
            endcase
            d = $urandom;
            case ($urandom_range(0, 2))
                0:       txn(1'b0, 1'b1, a, d, 1'b0, "rnd_wr");
                1:       txn(1'b1, 1'b1, a, d, 1'($urandom_range(0, 1)), "rnd_rw");
                default: txn(1'b1, 1'b0, a, d, 1'($urandom_range(0, 1)), "rnd_rd");
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
